// File: rtl/gray2rgb_pkg.sv
// Shared types and helpers for the grayscale-to-RGB colormap block.
package gray2rgb_pkg;

  localparam int unsigned PIX_W = 8;

  // Mapping select; encoding matches the i_mode port.
  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_INV  = 2'd1,
    MODE_JET  = 2'd2,
    MODE_HEAT = 2'd3
  } cmap_mode_t;

  // Jet segments, selected by gray[7:6]; each segment ramps one channel.
  localparam logic [1:0] JET_SEG_RISE_G = 2'd0;  // (0, f4, 255)
  localparam logic [1:0] JET_SEG_FALL_B = 2'd1;  // (0, 255, 255-f4)
  localparam logic [1:0] JET_SEG_RISE_R = 2'd2;  // (f4, 255, 0)
  localparam logic [1:0] JET_SEG_FALL_G = 2'd3;  // (255, 255-f4, 0)

  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  // 8-bit add or subtract through a 9-bit intermediate, clamped to 0..255.
  function automatic logic [PIX_W-1:0] sat_addsub8(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b,
                                                   input logic             sub);
    logic [PIX_W:0]   t;
    logic [PIX_W-1:0] res;
    if (sub) begin
      t   = {1'b0, a} - {1'b0, b};
      res = t[PIX_W] ? '0 : t[PIX_W-1:0];
    end else begin
      t   = {1'b0, a} + {1'b0, b};
      res = t[PIX_W] ? PIX_MAX : t[PIX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/gray2rgb_map.sv
// Combinational colormap: one 8-bit gray value to 24-bit RGB.
// Ports: gray  - input pixel value
//        mode  - mapping select
//        red_c, green_c, blue_c - mapped channels (combinational)
module gray2rgb_map
  import gray2rgb_pkg::*;
(
  input  logic [PIX_W-1:0] gray,
  input  cmap_mode_t       mode,
  output logic [PIX_W-1:0] red_c,
  output logic [PIX_W-1:0] green_c,
  output logic [PIX_W-1:0] blue_c
);

  logic [1:0]       seg_c;
  logic [PIX_W-1:0] f4_c;
  logic [PIX_W-1:0] f4_inv_c;
  logic [PIX_W-1:0] hot_c;

  // Channel selection per mapping.
  always_comb begin
    red_c    = '0;
    green_c  = '0;
    blue_c   = '0;
    seg_c    = gray[7:6];
    f4_c     = {gray[5:0], 2'b00};
    f4_inv_c = sat_addsub8(PIX_MAX, f4_c, 1'b1);
    // Heat green: excess above mid-scale, doubled; zero below 128.
    hot_c    = sat_addsub8(gray, 8'd128, 1'b1);
    case (mode)
      MODE_GRAY: begin
        red_c   = gray;
        green_c = gray;
        blue_c  = gray;
      end
      MODE_INV: begin
        red_c   = sat_addsub8(PIX_MAX, gray, 1'b1);
        green_c = sat_addsub8(PIX_MAX, gray, 1'b1);
        blue_c  = sat_addsub8(PIX_MAX, gray, 1'b1);
      end
      MODE_JET: begin
        case (seg_c)
          JET_SEG_RISE_G: begin red_c = '0;      green_c = f4_c;     blue_c = PIX_MAX;  end
          JET_SEG_FALL_B: begin red_c = '0;      green_c = PIX_MAX;  blue_c = f4_inv_c; end
          JET_SEG_RISE_R: begin red_c = f4_c;    green_c = PIX_MAX;  blue_c = '0;       end
          default:        begin red_c = PIX_MAX; green_c = f4_inv_c; blue_c = '0;       end
        endcase
      end
      default: begin
        red_c   = sat_addsub8(gray, gray, 1'b0);
        green_c = sat_addsub8(hot_c, hot_c, 1'b0);
        blue_c  = '0;
      end
    endcase
  end

endmodule

// File: rtl/gray2rgb_colormap.sv
// Expands an 8-bit gray/disparity stream to RGB with selectable colormap,
// tracks active-area position and flags line/frame end. Latency 2 cycles.
// Ports: clk, rst (sync, active-high)
//        i_clr        - clear x/y position counters
//        i_mode       - mapping select, latched at frame start (0,0)
//        i_DVAL/i_gray - input pixel stream
//        o_DVAL, o_Red/o_Green/o_Blue - mapped pixel, zero when invalid
//        o_line_end/o_frame_end - last pixel of line / of frame
module gray2rgb_colormap
  import gray2rgb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [1:0]       i_mode,
  input  logic             i_DVAL,
  input  logic [PIX_W-1:0] i_gray,
  output logic             o_DVAL,
  output logic [PIX_W-1:0] o_Red,
  output logic [PIX_W-1:0] o_Green,
  output logic [PIX_W-1:0] o_Blue,
  output logic             o_line_end,
  output logic             o_frame_end
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [XW-1:0]    x_q, pos_x_c, x_next_c;
  logic [YW-1:0]    y_q, pos_y_c, y_next_c;
  logic             at_origin_c, line_last_c, frame_last_c;
  cmap_mode_t       mode_r, mode_eff_c;

  logic             s1_valid, s1_line_end, s1_frame_end;
  logic [PIX_W-1:0] s1_gray;
  cmap_mode_t       s1_mode;
  logic [PIX_W-1:0] red_c, green_c, blue_c;

  // Position of the current pixel (clear makes it the origin) and next counters.
  always_comb begin
    pos_x_c      = i_clr ? '0 : x_q;
    pos_y_c      = i_clr ? '0 : y_q;
    at_origin_c  = (pos_x_c == '0) && (pos_y_c == '0);
    line_last_c  = (pos_x_c == XW'(H_ACTIVE - 1));
    frame_last_c = line_last_c && (pos_y_c == YW'(V_ACTIVE - 1));
    x_next_c     = pos_x_c;
    y_next_c     = pos_y_c;
    if (i_DVAL) begin
      if (line_last_c) begin
        x_next_c = '0;
        y_next_c = frame_last_c ? '0 : pos_y_c + YW'(1);
      end else begin
        x_next_c = pos_x_c + XW'(1);
      end
    end
    // A valid origin pixel takes the new mode immediately.
    mode_eff_c = (i_DVAL && at_origin_c) ? cmap_mode_t'(i_mode) : mode_r;
  end

  // Position counters and frame-latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_r <= MODE_GRAY;
    end else begin
      x_q    <= x_next_c;
      y_q    <= y_next_c;
      mode_r <= mode_eff_c;
    end
  end

  // Stage 1: pixel, valid, position flags, effective mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_gray      <= '0;
      s1_line_end  <= 1'b0;
      s1_frame_end <= 1'b0;
      s1_mode      <= MODE_GRAY;
    end else begin
      s1_valid     <= i_DVAL;
      s1_gray      <= i_gray;
      s1_line_end  <= i_DVAL && line_last_c;
      s1_frame_end <= i_DVAL && frame_last_c;
      s1_mode      <= mode_eff_c;
    end
  end

  gray2rgb_map u_map (
    .gray    (s1_gray),
    .mode    (s1_mode),
    .red_c   (red_c),
    .green_c (green_c),
    .blue_c  (blue_c)
  );

  // Stage 2: mapped RGB and flags, blanked to zero on invalid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_DVAL      <= 1'b0;
      o_Red       <= '0;
      o_Green     <= '0;
      o_Blue      <= '0;
      o_line_end  <= 1'b0;
      o_frame_end <= 1'b0;
    end else begin
      o_DVAL      <= s1_valid;
      o_Red       <= s1_valid ? red_c   : '0;
      o_Green     <= s1_valid ? green_c : '0;
      o_Blue      <= s1_valid ? blue_c  : '0;
      o_line_end  <= s1_valid && s1_line_end;
      o_frame_end <= s1_valid && s1_frame_end;
    end
  end

endmodule

// File: tb/tb_gray2rgb_colormap.sv
// Randomized and directed bench for gray2rgb_colormap against a frame-index model.
module tb_gray2rgb_colormap;

  localparam int H = 4;
  localparam int V = 2;

  logic       clk = 1'b0;
  logic       rst, i_clr, i_DVAL;
  logic [1:0] i_mode;
  logic [7:0] i_gray;
  logic       o_DVAL, o_line_end, o_frame_end;
  logic [7:0] o_Red, o_Green, o_Blue;

  gray2rgb_colormap #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (i_clr),
    .i_mode      (i_mode),
    .i_DVAL      (i_DVAL),
    .i_gray      (i_gray),
    .o_DVAL      (o_DVAL),
    .o_Red       (o_Red),
    .o_Green     (o_Green),
    .o_Blue      (o_Blue),
    .o_line_end  (o_line_end),
    .o_frame_end (o_frame_end)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  // Model state: linear index of the next pixel within the frame, latched mode.
  int          idx = 0;
  int          mode_m = 0;
  logic [26:0] pend = '0;
  logic [26:0] oq[$];
  int          gv[12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_map(input int g, input int m);
    int r, gr, b, s, f4;
    s  = g / 64;
    f4 = (g % 64) * 4;
    r = 0; gr = 0; b = 0;
    case (m)
      0: begin r = g; gr = g; b = g; end
      1: begin r = 255 - g; gr = 255 - g; b = 255 - g; end
      2: case (s)
           0: begin r = 0;   gr = f4;       b = 255;      end
           1: begin r = 0;   gr = 255;      b = 255 - f4; end
           2: begin r = f4;  gr = 255;      b = 0;        end
           default: begin r = 255; gr = 255 - f4; b = 0;  end
         endcase
      default: begin
        r  = (2 * g > 255) ? 255 : 2 * g;
        gr = (g >= 128) ? 2 * (g - 128) : 0;
        b  = 0;
      end
    endcase
    return {r[7:0], gr[7:0], b[7:0]};
  endfunction

  function automatic logic [26:0] pix(input logic [23:0] rgb, input logic le, input logic fe);
    return {1'b1, rgb, le, fe};
  endfunction

  // One clock: drive, sample #1 after the edge, compare with previous prediction.
  task automatic step(input logic r, input logic c, input logic d,
                      input logic [1:0] m, input logic [7:0] g);
    logic [26:0] obs;
    rst = r; i_clr = c; i_DVAL = d; i_mode = m; i_gray = g;
    @(posedge clk);
    #1;
    obs = {o_DVAL, o_Red, o_Green, o_Blue, o_line_end, o_frame_end};
    if (r) begin
      check("reset_out", 32'(obs), 32'd0);
      pend   = '0;
      idx    = 0;
      mode_m = 0;
    end else begin
      check("model", 32'(obs), 32'(pend));
      if (c) idx = 0;
      if (d) begin
        if (idx == 0) mode_m = int'(m);
        pend = pix(ref_map(int'(g), mode_m), (idx % H) == H - 1, idx == H * V - 1);
        idx  = (idx + 1) % (H * V);
      end else begin
        pend = '0;
      end
    end
    if (o_DVAL) oq.push_back(obs);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 2'($urandom), 8'($urandom));
  endtask

  task automatic send(input logic c, input logic [1:0] m, input logic [7:0] g);
    step(1'b0, c, 1'b1, m, g);
  endtask

  task automatic gap();
    idle(int'($urandom_range(0, 2)));
  endtask

  initial begin
    logic [26:0] e;
    // Reset and latency
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    oq.delete();
    send(1'b0, 2'd0, 8'd100);
    idle(3);
    check("latency_count", 32'(oq.size()), 32'd1);
    check("latency_pix", 32'(oq[0]), 32'(pix({8'd100, 8'd100, 8'd100}, 1'b0, 1'b0)));

    // Jet points, frame restarted by clear with the first pixel
    oq.delete();
    send(1'b1, 2'd2, 8'd0);
    send(1'b0, 2'd2, 8'd100);
    send(1'b0, 2'd2, 8'd200);
    send(1'b0, 2'd2, 8'd255);
    idle(3);
    check("jet_0",   32'(oq[0]), 32'(pix({8'd0,   8'd0,   8'd255}, 1'b0, 1'b0)));
    check("jet_100", 32'(oq[1]), 32'(pix({8'd0,   8'd255, 8'd111}, 1'b0, 1'b0)));
    check("jet_200", 32'(oq[2]), 32'(pix({8'd255, 8'd223, 8'd0},   1'b0, 1'b0)));
    check("jet_255", 32'(oq[3]), 32'(pix({8'd255, 8'd3,   8'd0},   1'b1, 1'b0)));

    // Heat and inverted
    oq.delete();
    send(1'b1, 2'd3, 8'd100);
    send(1'b0, 2'd0, 8'd200);
    idle(2);
    send(1'b1, 2'd1, 8'd30);
    idle(3);
    check("heat_100", 32'(oq[0][25:2]), 32'({8'd200, 8'd0,   8'd0}));
    check("heat_200", 32'(oq[1][25:2]), 32'({8'd255, 8'd144, 8'd0}));
    check("inv_30",   32'(oq[2][25:2]), 32'({8'd225, 8'd225, 8'd225}));

    // Line/frame wrap with random gaps; pixel 9 is the origin of the next frame
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    oq.delete();
    for (int i = 0; i < 9; i++) begin
      gv[i] = int'($urandom_range(0, 255));
      send(1'b0, (i == 8) ? 2'd3 : 2'd0, 8'(gv[i]));
      gap();
    end
    idle(3);
    check("wrap_count", 32'(oq.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      e = oq[i];
      check("wrap_line_end",  32'(e[1]), 32'(i == 3 || i == 7));
      check("wrap_frame_end", 32'(e[0]), 32'(i == 7));
    end
    e = oq[8];
    check("wrap_origin_heat", 32'(e[25:2]), 32'(ref_map(gv[8], 3)));

    // Mode change mid-frame takes effect at next frame start
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    oq.delete();
    for (int i = 0; i < 8; i++) begin
      gv[i] = int'($urandom_range(0, 255));
      send(1'b0, (i < 2) ? 2'd0 : 2'd2, 8'(gv[i]));
    end
    send(1'b0, 2'd2, 8'd100);
    idle(3);
    for (int i = 2; i < 8; i++) begin
      e = oq[i];
      check("latch_gray", 32'(e[25:2]), 32'({8'(gv[i]), 8'(gv[i]), 8'(gv[i])}));
    end
    e = oq[8];
    check("latch_jet", 32'(e[25:2]), 32'({8'd0, 8'd255, 8'd111}));

    // Clear coincident with a valid pixel at (2,1)
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    oq.delete();
    for (int i = 0; i < 11; i++) send(i == 6, 2'd0, 8'($urandom));
    idle(3);
    check("clr_count", 32'(oq.size()), 32'd11);
    for (int i = 4; i < 11; i++) begin
      e = oq[i];
      check("clr_line_end",  32'(e[1]), 32'(i == 9));
      check("clr_frame_end", 32'(e[0]), 32'd0);
    end

    // Random traffic including occasional clear and reset
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray2rgb_colormap.md
# gray2rgb_colormap

Display-side counterpart of the grayscale converter. Takes an 8-bit grayscale or disparity pixel stream qualified by `i_DVAL` and expands it back to 24-bit RGB for the VGA output path. Four selectable mappings are available: grayscale replicate, inverted gray, jet pseudocolor and heat. The block also tracks active-area position and flags the last pixel of each line and of each frame. It sits between the disparity/gray pipeline and the VGA output mux.

## Interface
Parameters:
- `H_ACTIVE`, 640: valid pixels per line.
- `V_ACTIVE`, 480: lines per frame.

Ports:
- `clk` input 1: single clock; the whole block is in this domain.
- `rst` input 1: reset, synchronous, active-high.
- `i_clr` input 1: synchronous clear of the x/y position counters, typically driven by VSYNC.
- `i_mode` input 2: mapping select (0 gray, 1 inverted, 2 jet, 3 heat).
- `i_DVAL` input 1: input pixel valid.
- `i_gray` input 8: input pixel value.
- `o_DVAL` output 1: output pixel valid.
- `o_Red`, `o_Green`, `o_Blue` output 8 each: mapped pixel.
- `o_line_end` output 1: output pixel is x = H_ACTIVE-1.
- `o_frame_end` output 1: output pixel is x = H_ACTIVE-1 and y = V_ACTIVE-1.

## Operation
- **Position counters.** `x` counts 0..H_ACTIVE-1 and `y` counts 0..V_ACTIVE-1.
  - Both advance only on an `i_DVAL` cycle.
  - `x` wraps to 0 after H_ACTIVE-1; `y` increments on that wrap.
  - `y` wraps to 0 after V_ACTIVE-1, so the counters are free-running across frames.
  - Gaps in `i_DVAL` hold both counters.
- **Clear.** `i_clr` forces `x` and `y` to 0 and has priority over counting.
  - If `i_clr` and `i_DVAL` are high in the same cycle, that pixel is position (0,0).
  - The next valid pixel is then position (1,0).
- **Mode latch.** The mode register `mode_r` loads `i_mode` only on a valid pixel at position (0,0).
  - That pixel already uses the new mode.
  - A change of `i_mode` mid-frame has no effect until the next frame start.
- **Mapping.** Let g be `i_gray`, s = g[7:6], f = g[5:0] and f4 = {f,2'b00}, with range 0..252.
  - Gray: R = G = B = g.
  - Inverted: R = G = B = 255 - g.
  - Jet:
    - s = 0: (0, f4, 255).
    - s = 1: (0, 255, 255 - f4).
    - s = 2: (f4, 255, 0).
    - s = 3: (255, 255 - f4, 0).
  - Heat:
    - R = min(2g, 255).
    - G = 2(g - 128) if g ≥ 128, else 0.
    - B = 0.
  - All arithmetic uses 9-bit intermediates with explicit saturation. No wrap-around is permitted in any channel.
- **Invalid cycles.** While `o_DVAL` is low, `o_Red`, `o_Green`, `o_Blue`, `o_line_end` and `o_frame_end` are all 0. This provides blanking for the VGA path.

## Timing
- **Pipeline.** Two register stages, so latency is exactly 2 cycles from `i_DVAL`/`i_gray` to `o_DVAL`/RGB.
  - Stage 1 registers: g, valid, the end-of-line and end-of-frame flags for the current position, and the effective mode. The effective mode is the new mode on a (0,0) pixel, otherwise `mode_r`.
  - Stage 2 registers: mapped RGB and the delayed flags.
- **Throughput.** One pixel per cycle, with no backpressure. Back-to-back valid pixels are accepted indefinitely.
- **Flag alignment.** `o_line_end` and `o_frame_end` are cycle-aligned with the RGB of the pixel they describe.
- **Reset.** All outputs are 0 after reset: `o_DVAL` 0, RGB 0, both flags 0.
  - `x`, `y` and `mode_r` reset to 0, i.e. gray mode.
  - Pixels in flight are discarded.
  - `rst` has priority over `i_clr` and `i_DVAL`.
- **Reset mid-frame.** The first valid pixel after `rst` deasserts is position (0,0) and latches the mode.

## Structure
- **Package `gray2rgb_pkg`:**
  - enum `cmap_mode_t`: MODE_GRAY, MODE_INV, MODE_JET, MODE_HEAT.
  - jet segment constants.
  - an 8-bit saturating add/sub function.
- **Sub-module `gray2rgb_map`:** purely combinational (g, mode) → (R, G, B), instanced between stage 1 and stage 2. Counters, mode latch and pipeline registers stay in the top module.

## Test plan
- **Reset and latency:** assert `rst` for 3 cycles, then send a single valid pixel with g=100, mode 0.
  - During reset all outputs are 0.
  - The output appears exactly 2 cycles later as (100,100,100) with `o_DVAL` high for 1 cycle.
- **Jet points:** mode 2, send g=0, 100, 200, 255 back-to-back. Required outputs in order:
  - (0,0,255)
  - (0,255,111)
  - (255,223,0)
  - (255,3,0)
- **Heat and inverted:**
  - Heat with g=100 gives (200,0,0); heat with g=200 gives (255,144,0).
  - Inverted with g=30 gives (225,225,225).
- **Line/frame wrap:** use H_ACTIVE=4, V_ACTIVE=2 with 8 valid pixels and random `i_DVAL` gaps.
  - `o_line_end` is high on pixels 4 and 8.
  - `o_frame_end` is high on pixel 8 only.
  - Pixel 9 is position (0,0).
- **Mode latch:** switch `i_mode` from 0 to 2 at mid-frame pixel 3.
  - The rest of the frame stays gray.
  - The next frame's first pixel is jet-mapped.
- **Clear coincident with valid:** assert `i_clr` together with `i_DVAL` at position (2,1).
  - That pixel is treated as (0,0).
  - `o_line_end` is next seen H_ACTIVE valid pixels later.
